// File: rtl/packet_builder.sv
// packet_builder: serializes one parallel payload (1..37 bytes) plus stream ID
// into a 32-bit word stream: {len+8, streamId}, sequence number, then data
// words. A per-stream sequence table gives consecutive packets on a stream
// consecutive sequence numbers starting at 1.
// Optional build macro PACKET_BUILDER_LOSS_INJECT_EN adds an injectSkip input
// that advances the sequence by 2 instead of 1 for the accepted packet.
module packet_builder #(
  parameter int STREAM_IDX_W      = 5,
  parameter int MAX_PAYLOAD_BYTES = 37
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic [0:295]  payloadIn,
  input  logic [5:0]    payloadLen,
  input  logic [15:0]   streamIn,
  input  logic          payloadIn_val,
  output logic          payloadIn_ready,
  output logic [31:0]   dataOut,
  output logic          dataOut_val,
  input  logic          dataOut_ready,
  output logic          dataOut_last,
`ifdef PACKET_BUILDER_LOSS_INJECT_EN
  input  logic          injectSkip,
`endif
  output logic          lenError
);

  localparam int         DEPTH   = 1 << STREAM_IDX_W;
  localparam logic [5:0] MAX_LEN = 6'(MAX_PAYLOAD_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR0 = 2'd1;
  localparam logic [1:0] S_HDR1 = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  logic [1:0]  r_state;
  logic [3:0]  r_widx;
  logic        r_len_err;
  logic [0:295] r_payload;
  logic [5:0]  r_len;
  logic [15:0] r_stream;
  logic [31:0] r_seq;
  logic [31:0] r_tbl [DEPTH];

  logic                    w_accept;
  logic                    w_len_ok;
  logic                    w_fire;
  logic [STREAM_IDX_W-1:0] w_idx;
  logic [31:0]             w_inc;
  logic [31:0]             w_next_seq;
  logic [5:0]              w_base;
  logic                    w_last_word;
  logic [0:319]            w_pad;
  logic [31:0]             w_data_word;

  assign payloadIn_ready = (r_state == S_IDLE);
  assign dataOut_val     = (r_state != S_IDLE);
  assign lenError        = r_len_err;

  assign w_accept   = payloadIn_val & payloadIn_ready;
  assign w_len_ok   = (payloadLen != 6'd0) && (payloadLen <= MAX_LEN);
  assign w_fire     = dataOut_val & dataOut_ready;
  assign w_idx      = streamIn[STREAM_IDX_W-1:0];
`ifdef PACKET_BUILDER_LOSS_INJECT_EN
  assign w_inc      = injectSkip ? 32'd2 : 32'd1;
`else
  assign w_inc      = 32'd1;
`endif
  assign w_next_seq = r_tbl[w_idx] + w_inc;

  // First byte index of the current data word; the word is final once it
  // covers the last payload byte.
  assign w_base       = {r_widx, 2'b00};
  assign w_last_word  = ((w_base + 6'd4) >= r_len);
  assign dataOut_last = (r_state == S_DATA) && w_last_word;

  // Padding lets the final word index past byte 36 without going out of range.
  assign w_pad = {r_payload, 24'd0};

  // Assemble the current data word, zeroing bytes past the payload length.
  always_comb begin
    w_data_word = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if ((w_base + 6'(j)) < r_len)
        w_data_word[31-8*j -: 8] = w_pad[(int'(w_base) + j) * 8 +: 8];
    end
  end

  // Output word multiplexer: zero when idle.
  always_comb begin
    case (r_state)
      S_HDR0:  dataOut = {({10'd0, r_len} + 16'd8), r_stream};
      S_HDR1:  dataOut = r_seq;
      S_DATA:  dataOut = w_data_word;
      default: dataOut = 32'd0;
    endcase
  end

  // Control FSM: accept in IDLE, advance on each output handshake.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state   <= S_IDLE;
      r_widx    <= 4'd0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_accept & ~w_len_ok;
      case (r_state)
        S_IDLE: if (w_accept && w_len_ok) r_state <= S_HDR0;
        S_HDR0: if (w_fire) r_state <= S_HDR1;
        S_HDR1: if (w_fire) begin
          r_state <= S_DATA;
          r_widx  <= 4'd0;
        end
        S_DATA: if (w_fire) begin
          if (w_last_word) r_state <= S_IDLE;
          else             r_widx  <= r_widx + 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Packet capture: inputs are latched once at a legal acceptance.
  always_ff @(posedge clk) begin
    if (w_accept && w_len_ok) begin
      r_payload <= payloadIn;
      r_len     <= payloadLen;
      r_stream  <= streamIn;
      r_seq     <= w_next_seq;
    end
  end

  // Sequence table: cleared on reset, written back at legal acceptance.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      for (int i = 0; i < DEPTH; i++) r_tbl[i] <= 32'd0;
    end else if (w_accept && w_len_ok) begin
      r_tbl[w_idx] <= w_next_seq;
    end
  end

endmodule

// File: tb/tb_packet_builder.sv
// Self-checking bench for packet_builder: directed scenarios plus randomized
// packets compared against a reference model of the packet format.
module tb_packet_builder;

  logic          clk = 1'b0;
  logic          reset_b;
  logic [0:295]  payloadIn;
  logic [5:0]    payloadLen;
  logic [15:0]   streamIn;
  logic          payloadIn_val;
  logic          payloadIn_ready;
  logic [31:0]   dataOut;
  logic          dataOut_val;
  logic          dataOut_ready;
  logic          dataOut_last;
  logic          lenError;
`ifdef PACKET_BUILDER_LOSS_INJECT_EN
  logic          injectSkip;
`endif

  packet_builder dut (
    .clk             (clk),
    .reset_b         (reset_b),
    .payloadIn       (payloadIn),
    .payloadLen      (payloadLen),
    .streamIn        (streamIn),
    .payloadIn_val   (payloadIn_val),
    .payloadIn_ready (payloadIn_ready),
    .dataOut         (dataOut),
    .dataOut_val     (dataOut_val),
    .dataOut_ready   (dataOut_ready),
    .dataOut_last    (dataOut_last),
`ifdef PACKET_BUILDER_LOSS_INJECT_EN
    .injectSkip      (injectSkip),
`endif
    .lenError        (lenError)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: last sequence number sent per table index.
  logic [31:0] m_tbl [32];
  logic [7:0]  m_bytes [37];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_tbl[i] = 32'd0;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    cycle();
    cycle();
    check("rst_val",  {31'd0, dataOut_val},  32'd0);
    check("rst_last", {31'd0, dataOut_last}, 32'd0);
    check("rst_data", dataOut,               32'd0);
    check("rst_lerr", {31'd0, lenError},     32'd0);
    reset_b = 1'b1;
    check("rst_ready", {31'd0, payloadIn_ready}, 32'd1);
    model_clear();
  endtask

  // Offer one payload and follow it to the end.
  // rmode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic send(input logic [15:0] sid, input int len, input int rmode, input bit skip);
    logic [31:0] exp_w [$];
    logic [31:0] word, seq;
    logic [0:295] pin;
    bit legal, r;
    int nw, i, cyc, b;
    legal = (len >= 1) && (len <= 37);
    check("in_ready", {31'd0, payloadIn_ready}, 32'd1);
    for (int k = 0; k < 37; k++) begin
      m_bytes[k] = 8'($urandom);
      pin[8*k +: 8] = m_bytes[k];
    end
    payloadIn     = pin;
    payloadLen    = 6'(len);
    streamIn      = sid;
    payloadIn_val = 1'b1;
`ifdef PACKET_BUILDER_LOSS_INJECT_EN
    injectSkip    = skip;
`endif
    cycle();
    payloadIn_val = 1'b0;
    payloadIn     = {296{1'b1}} ^ pin;
    payloadLen    = 6'($urandom);
    streamIn      = 16'($urandom);
`ifdef PACKET_BUILDER_LOSS_INJECT_EN
    injectSkip    = 1'($urandom);
`endif
    if (!legal) begin
      check("lerr_pulse", {31'd0, lenError},    32'd1);
      check("lerr_noval", {31'd0, dataOut_val}, 32'd0);
      cycle();
      check("lerr_clear", {31'd0, lenError},    32'd0);
      check("lerr_noval2", {31'd0, dataOut_val}, 32'd0);
      check("lerr_ready", {31'd0, payloadIn_ready}, 32'd1);
      return;
    end
    check("lerr_none", {31'd0, lenError}, 32'd0);
    seq = m_tbl[sid[4:0]] + (skip ? 32'd2 : 32'd1);
    m_tbl[sid[4:0]] = seq;
    exp_w.push_back({16'(len + 8), sid});
    exp_w.push_back(seq);
    for (int w = 0; w < (len + 3) / 4; w++) begin
      word = 32'd0;
      for (int j = 0; j < 4; j++) begin
        b = 4 * w + j;
        word = {word[23:0], (b < len) ? m_bytes[b] : 8'd0};
      end
      exp_w.push_back(word);
    end
    nw  = exp_w.size();
    i   = 0;
    cyc = 0;
    while (i < nw && cyc < 200) begin
      check("val",  {31'd0, dataOut_val},  32'd1);
      check("word", dataOut,               exp_w[i]);
      check("last", {31'd0, dataOut_last}, {31'd0, (i == nw - 1)});
      check("busy", {31'd0, payloadIn_ready}, 32'd0);
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      dataOut_ready = r;
      cycle();
      if (r) i++;
      cyc++;
    end
    check("pkt_done", {31'd0, (i == nw)}, 32'd1);
    dataOut_ready = 1'b1;
    check("idle_val",   {31'd0, dataOut_val},     32'd0);
    check("idle_ready", {31'd0, payloadIn_ready}, 32'd1);
  endtask

  initial begin
    reset_b       = 1'b0;
    payloadIn     = '0;
    payloadLen    = 6'd0;
    streamIn      = 16'd0;
    payloadIn_val = 1'b0;
    dataOut_ready = 1'b1;
`ifdef PACKET_BUILDER_LOSS_INJECT_EN
    injectSkip    = 1'b0;
`endif
    model_clear();
    do_reset();

    // Basic 5-byte packet with known bytes 0x11..0x15.
    check("in_ready0", {31'd0, payloadIn_ready}, 32'd1);
    payloadIn = '0;
    for (int k = 0; k < 5; k++) payloadIn[8*k +: 8] = 8'(8'h11 + k);
    payloadLen = 6'd5; streamIn = 16'h0003; payloadIn_val = 1'b1;
    cycle();
    payloadIn_val = 1'b0;
    m_tbl[3] = 32'd1;
    check("t1_w0", dataOut, 32'h000D0003); cycle();
    check("t1_w1", dataOut, 32'h00000001); cycle();
    check("t1_w2", dataOut, 32'h11121314);
    check("t1_l2", {31'd0, dataOut_last}, 32'd0); cycle();
    check("t1_w3", dataOut, 32'h15000000);
    check("t1_l3", {31'd0, dataOut_last}, 32'd1); cycle();
    check("t1_ready", {31'd0, payloadIn_ready}, 32'd1);

    // Stream aliasing on index 3.
    do_reset();
    send(16'h0003, 4, 0, 1'b0);
    send(16'h0003, 4, 0, 1'b0);
    send(16'h0023, 4, 0, 1'b0);

    // Maximum length with a stalling sink.
    send(16'h0011, 37, 1, 1'b0);

    // Illegal lengths, then a legal packet on the same stream.
    send(16'h0009, 0,  0, 1'b0);
    send(16'h0009, 38, 0, 1'b0);
    send(16'h0009, 8,  2, 1'b0);

    // Reset during HDR1 with the sink stalled.
    send(16'h0005, 6, 0, 1'b0);
    payloadIn_val = 1'b1; payloadLen = 6'd9; streamIn = 16'h0005;
    cycle();
    payloadIn_val = 1'b0;
    cycle();
    dataOut_ready = 1'b0;
    check("t5_hdr1", dataOut, 32'h00000002);
    reset_b = 1'b0;
    cycle();
    reset_b = 1'b1;
    dataOut_ready = 1'b1;
    model_clear();
    check("t5_val",  {31'd0, dataOut_val},  32'd0);
    check("t5_last", {31'd0, dataOut_last}, 32'd0);
    send(16'h0005, 7, 0, 1'b0);

`ifdef PACKET_BUILDER_LOSS_INJECT_EN
    // Loss injection: seq 1, 3, 4; skip ignored on an illegal drop.
    send(16'h0007, 3, 0, 1'b0);
    send(16'h0007, 3, 0, 1'b1);
    send(16'h0007, 0, 0, 1'b1);
    send(16'h0007, 3, 0, 1'b0);
`endif

    // Randomized traffic.
    for (int p = 0; p < 40; p++) begin
      bit sk;
      sk = 1'b0;
`ifdef PACKET_BUILDER_LOSS_INJECT_EN
      sk = 1'($urandom);
`endif
      send(16'($urandom_range(0, 3) * 32 + $urandom_range(0, 3)),
           $urandom_range(0, 40), 2, sk && 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
